// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset and lock sequencer for the core PLL, clocked by the free-running reference clock
//
// Ports:
//   clk            free-running reference clock (also feeds the PLL)
//   rst_n          asynchronous active-low reset
//   pll_locked_i   PLL locked indication, asynchronous to clk
//   ext_reset_i    user reset request, active-high, asynchronous
//   pll_rst_o      PLL reset, active-high, registered
//   sys_reset_o    system reset, active-high, asynchronous assert / synchronous deassert
//   ready_o        high only while running (always ~sys_reset_o)
//   lock_lost_o    one-cycle pulse when lock drops while running
//   relock_count_o saturating count of timeout-triggered PLL resets
//
// Build option PLL_RELOCK_EN: when defined, a WAIT_LOCK timeout and a lock loss
// while running both re-pulse the PLL reset. When undefined, WAIT_LOCK waits
// forever, lock loss returns to WAIT_LOCK and relock_count_o stays 0.
`timescale 1ns/1ps
module pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_PULSE      = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 256,
    parameter int RELOCK_TIMEOUT     = 65536,
    parameter int CNT_W              = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       ext_reset_i,
    output logic       pll_rst_o,
    output logic       sys_reset_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] relock_count_o
);
`ifdef PLL_RELOCK_EN
    localparam bit RELOCK_EN = 1'b1;
`else
    localparam bit RELOCK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, ext_sync_q;
    logic                   locked_s, ext_s;
    logic                   pll_rst_q, sys_reset_q, lock_lost_q, lost_d;
    logic [7:0]             relock_q, relock_d;

    assign locked_s       = lock_sync_q[SYNC_STAGES-1];
    assign ext_s          = ext_sync_q[SYNC_STAGES-1];
    assign pll_rst_o      = pll_rst_q;
    assign sys_reset_o    = sys_reset_q;
    assign ready_o        = ~sys_reset_q;
    assign lock_lost_o    = lock_lost_q;
    assign relock_count_o = relock_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        lost_d   = 1'b0;
        relock_d = relock_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_PULSE - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                // The cycle that first sees lock is the first stable cycle, which makes
                // lock-to-release exactly SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = CNT_W'(1);
                end else if (RELOCK_EN && cnt_q == CNT_W'(RELOCK_TIMEOUT - 1)) begin
                    state_d  = PLL_RST;
                    cnt_d    = '0;
                    relock_d = (relock_q == 8'hff) ? relock_q : relock_q + 8'd1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (ext_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    lost_d  = 1'b1;
                    state_d = RELOCK_EN ? PLL_RST : WAIT_LOCK;
                end else if (ext_s) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            ext_sync_q  <= '0;
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            lock_lost_q <= 1'b0;
            relock_q    <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
            ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], ext_reset_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= (state_d == PLL_RST);
            sys_reset_q <= (state_d != RUN);
            lock_lost_q <= lost_d;
            relock_q    <= relock_d;
        end
    end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: randomized self-checking bench for pll_reset_seq against arithmetic timing expectations
`timescale 1ns/1ps
module tb_pll_reset_seq;
    localparam int SYNC   = 2;
    localparam int PULSE  = 3;
    localparam int STABLE = 8;
    localparam int HOLDC  = 4;
    localparam int TMO    = 32;
`ifdef PLL_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif
    localparam int LAT_LOCK    = SYNC + STABLE + HOLDC;
    localparam int LAT_LOST    = SYNC + 1;
    localparam int LAT_EXT_ON  = SYNC + 1;
    localparam int LAT_EXT_OFF = SYNC + HOLDC;
    localparam int PERIOD      = PULSE + TMO;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       ext_reset_i = 1'b0;
    logic       pll_rst_o, sys_reset_o, ready_o, lock_lost_o;
    logic [7:0] relock_count_o;

    int n_chk = 0;
    int n_pass = 0;

    pll_reset_seq #(
        .SYNC_STAGES(SYNC), .PLL_RST_PULSE(PULSE), .LOCK_STABLE_CYCLES(STABLE),
        .RESET_HOLD_CYCLES(HOLDC), .RELOCK_TIMEOUT(TMO), .CNT_W(17)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked_i(pll_locked_i), .ext_reset_i(ext_reset_i),
        .pll_rst_o(pll_rst_o), .sys_reset_o(sys_reset_o), .ready_o(ready_o),
        .lock_lost_o(lock_lost_o), .relock_count_o(relock_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sig(input int sel);
        return sel == 0 ? int'(pll_rst_o) : sel == 1 ? int'(sys_reset_o) : int'(lock_lost_o);
    endfunction

    // Steps until the selected output reaches lvl; returns edges taken (limit on timeout).
    task automatic wait_for(input int sel, input int lvl, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sig(sel) != lvl && n < limit);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pllrst"}, int'(pll_rst_o), 1);
        check({tag, "_sys"}, int'(sys_reset_o), 1);
        check({tag, "_rdy"}, int'(ready_o), 0);
        check({tag, "_lost"}, int'(lock_lost_o), 0);
        check({tag, "_relock"}, int'(relock_count_o), 0);
    endtask

    task automatic ext_pulse(input int e);
        int exp;
        ext_reset_i = 1'b1;
        for (int k = 1; k <= e + LAT_EXT_OFF + 2; k++) begin
            step();
            if (k == e) ext_reset_i = 1'b0;
            exp = (k >= LAT_EXT_ON && k < e + LAT_EXT_OFF) ? 1 : 0;
            check("ext_sys", int'(sys_reset_o), exp);
            check("ext_rdy", int'(ready_o), 1 - exp);
            check("ext_lost", int'(lock_lost_o), 0);
        end
    endtask

    task automatic lose_lock();
        int n;
        pll_locked_i = 1'b0;
        wait_for(2, 1, 20, n);
        check("lost_lat", n, LAT_LOST);
        check("lost_sys", int'(sys_reset_o), 1);
        check("lost_rdy", int'(ready_o), 0);
        check("lost_pllrst", int'(pll_rst_o), int'(RELOCK));
        step();
        check("lost_width", int'(lock_lost_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, h, l, d;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst");
        step();
        step();
        rst_n = 1'b1;
        wait_for(0, 0, 20, n);
        check("pwr_pulse", n, PULSE);
        for (int i = 0; i < 10 - PULSE; i++) step();
        pll_locked_i = 1'b1;
        wait_for(1, 0, 60, n);
        check("pwr_lat", n, LAT_LOCK);
        check("pwr_rdy", int'(ready_o), 1);
        check("pwr_pllrst", int'(pll_rst_o), 0);
        check("pwr_relock", int'(relock_count_o), 0);

        ext_pulse(6);
        ext_pulse(int'($urandom_range(8, 1)));

        lose_lock();
        d = int'($urandom_range(18, 3));
        for (int i = 0; i < d; i++) step();
        h = int'($urandom_range(STABLE - 1, 1));
        l = int'($urandom_range(4, 1));
        pll_locked_i = 1'b1;
        for (int i = 0; i < h; i++) step();
        pll_locked_i = 1'b0;
        for (int i = 0; i < l; i++) step();
        pll_locked_i = 1'b1;
        wait_for(1, 0, 60, n);
        check("glitch_lat", n, LAT_LOCK);
        check("glitch_rdy", int'(ready_o), 1);

        lose_lock();
        for (int k = 2; k <= 3 * PERIOD; k++) begin
            step();
            check("tmo_pllrst", int'(pll_rst_o), (RELOCK && (k % PERIOD) < PULSE) ? 1 : 0);
            check("tmo_relock", int'(relock_count_o), RELOCK ? k / PERIOD : 0);
        end
        for (int i = 0; i < PULSE + 2; i++) step();
        pll_locked_i = 1'b1;
        for (int i = 0; i < LAT_LOCK - 2; i++) step();
        check("hold_sys", int'(sys_reset_o), 1);
        check("hold_pllrst", int'(pll_rst_o), 0);
        check("hold_relock", int'(relock_count_o), RELOCK ? 3 : 0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        step();
        rst_n = 1'b1;
        wait_for(0, 0, 20, n);
        check("re_pulse", n, PULSE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
